// File: rtl/debug_ocimem_ctrl.sv
// debug_ocimem_ctrl
//   Debug-monitor memory bridge. Command pulses from the debug-slave sysclk
//   stage load the monitor address/data registers and launch single-word
//   reads or writes on an Avalon-MM style master port. A per-transaction
//   timeout aborts stalled transfers and raises a sticky error flag.
//
// Ports
//   clk, reset                 rising-edge clock, synchronous active-high reset
//   jdo[37:0]                  JTAG data word (address in [ADDR_W+25:26],
//                              read-after-load flag in [35], data in [34:3])
//   take_action_ocimem_a       pulse: load address, optionally read
//   take_action_ocimem_b       pulse: write data word at current address
//   take_no_action_ocimem_a    pulse: read at current address
//   avm_*                      debug memory master port
//   MonDReg                    data register returned to the TCK stage
//   monitor_ready              no operation in flight, MonDReg valid
//   monitor_error              sticky error (timeout or command while busy)
//   busy                       controller not idle
module debug_ocimem_ctrl #(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [37:0]       jdo,
   input  logic              take_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic              take_no_action_ocimem_a,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_read,
   output logic              avm_write,
   output logic [31:0]       avm_writedata,
   input  logic              avm_waitrequest,
   input  logic [31:0]       avm_readdata,
   input  logic              avm_readdatavalid,
   output logic [31:0]       MonDReg,
   output logic              monitor_ready,
   output logic              monitor_error,
   output logic              busy
);

   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] RD_CMD  = 2'd1;
   localparam logic [1:0] RD_DATA = 2'd2;
   localparam logic [1:0] WR_CMD  = 2'd3;

   localparam int unsigned       CNT_W   = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
   localparam logic [ADDR_W-1:0] A_ONE   = ADDR_W'(1);

   logic [1:0]        state_q,     state_d;
   logic [ADDR_W-1:0] mon_areg_q,  mon_areg_d;
   logic [31:0]       mon_dreg_q,  mon_dreg_d;
   logic              rd_req_q,    rd_req_d;
   logic              wr_req_q,    wr_req_d;
   logic [ADDR_W-1:0] addr_q,      addr_d;
   logic [31:0]       wdata_q,     wdata_d;
   logic              ready_q,     ready_d;
   logic              error_q,     error_d;
   logic [CNT_W-1:0]  tmo_cnt_q,   tmo_cnt_d;

   logic              any_cmd;
   logic              op_done;
   logic [ADDR_W-1:0] jdo_addr;

   // Bits of jdo that carry no meaning for this block.
   logic              unused_jdo;
   assign unused_jdo = &{1'b0, jdo[37:36], jdo[2:0]};

   assign jdo_addr = jdo[ADDR_W+25:26];
   assign any_cmd  = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

   always_comb begin
      state_d    = state_q;
      mon_areg_d = mon_areg_q;
      mon_dreg_d = mon_dreg_q;
      rd_req_d   = rd_req_q;
      wr_req_d   = wr_req_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      ready_d    = ready_q;
      error_d    = error_q;
      tmo_cnt_d  = tmo_cnt_q;
      op_done    = 1'b0;

      if (state_q == IDLE) begin
         // Priority b > a > no_action; losers are dropped.
         if (take_action_ocimem_b) begin
            mon_dreg_d = jdo[34:3];
            wdata_d    = jdo[34:3];
            addr_d     = mon_areg_q;
            wr_req_d   = 1'b1;
            ready_d    = 1'b0;
            error_d    = 1'b0;
            tmo_cnt_d  = '0;
            state_d    = WR_CMD;
         end else if (take_action_ocimem_a) begin
            mon_areg_d = jdo_addr;
            error_d    = 1'b0;
            if (jdo[35]) begin
               addr_d    = jdo_addr;
               rd_req_d  = 1'b1;
               ready_d   = 1'b0;
               tmo_cnt_d = '0;
               state_d   = RD_CMD;
            end
         end else if (take_no_action_ocimem_a) begin
            addr_d    = mon_areg_q;
            rd_req_d  = 1'b1;
            ready_d   = 1'b0;
            error_d   = 1'b0;
            tmo_cnt_d = '0;
            state_d   = RD_CMD;
         end
      end else begin
         if (any_cmd) begin
            error_d = 1'b1;
         end
         tmo_cnt_d = tmo_cnt_q + CNT_ONE;

         case (state_q)
            RD_CMD: begin
               if (!avm_waitrequest) begin
                  rd_req_d = 1'b0;
                  state_d  = RD_DATA;
               end
            end
            RD_DATA: begin
               if (avm_readdatavalid) begin
                  op_done    = 1'b1;
                  mon_dreg_d = avm_readdata;
                  mon_areg_d = mon_areg_q + A_ONE;
                  ready_d    = 1'b1;
                  state_d    = IDLE;
               end
            end
            WR_CMD: begin
               if (!avm_waitrequest) begin
                  op_done    = 1'b1;
                  wr_req_d   = 1'b0;
                  mon_areg_d = mon_areg_q + A_ONE;
                  ready_d    = 1'b1;
                  state_d    = IDLE;
               end
            end
            default: begin
               state_d = IDLE;
            end
         endcase

         // A completing transfer wins over a timeout in the same cycle;
         // a read accepted in its last allowed cycle is still aborted since
         // its data phase has no time left.
         if (!op_done && (tmo_cnt_q == TO_LAST)) begin
            rd_req_d   = 1'b0;
            wr_req_d   = 1'b0;
            mon_areg_d = mon_areg_q;
            mon_dreg_d = mon_dreg_q;
            ready_d    = 1'b1;
            error_d    = 1'b1;
            state_d    = IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         mon_areg_q <= '0;
         mon_dreg_q <= '0;
         rd_req_q   <= 1'b0;
         wr_req_q   <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         ready_q    <= 1'b1;
         error_q    <= 1'b0;
         tmo_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         mon_areg_q <= mon_areg_d;
         mon_dreg_q <= mon_dreg_d;
         rd_req_q   <= rd_req_d;
         wr_req_q   <= wr_req_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         ready_q    <= ready_d;
         error_q    <= error_d;
         tmo_cnt_q  <= tmo_cnt_d;
      end
   end

   assign avm_address   = addr_q;
   assign avm_read      = rd_req_q;
   assign avm_write     = wr_req_q;
   assign avm_writedata = wdata_q;
   assign MonDReg       = mon_dreg_q;
   assign monitor_ready = ready_q;
   assign monitor_error = error_q;
   assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_debug_ocimem_ctrl.sv
// tb_debug_ocimem_ctrl
//   Scoreboard bench for debug_ocimem_ctrl: a command-level reference model
//   pushes expected bus transfers and completions into a queue, a monitor
//   pops and compares them as the DUT presents them, and a memory slave with
//   random stalls serves the master port.
module tb_debug_ocimem_ctrl;

   localparam int AW = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [37:0]   jdo = '0;
   logic          take_action_ocimem_a = 1'b0;
   logic          take_action_ocimem_b = 1'b0;
   logic          take_no_action_ocimem_a = 1'b0;
   logic [AW-1:0] avm_address;
   logic          avm_read;
   logic          avm_write;
   logic [31:0]   avm_writedata;
   logic          avm_waitrequest = 1'b0;
   logic [31:0]   avm_readdata = '0;
   logic          avm_readdatavalid = 1'b0;
   logic [31:0]   MonDReg;
   logic          monitor_ready;
   logic          monitor_error;
   logic          busy;

   debug_ocimem_ctrl #(.ADDR_W(AW), .TIMEOUT(255)) dut (
      .clk                     (clk),
      .reset                   (reset),
      .jdo                     (jdo),
      .take_action_ocimem_a    (take_action_ocimem_a),
      .take_action_ocimem_b    (take_action_ocimem_b),
      .take_no_action_ocimem_a (take_no_action_ocimem_a),
      .avm_address             (avm_address),
      .avm_read                (avm_read),
      .avm_write               (avm_write),
      .avm_writedata           (avm_writedata),
      .avm_waitrequest         (avm_waitrequest),
      .avm_readdata            (avm_readdata),
      .avm_readdatavalid       (avm_readdatavalid),
      .MonDReg                 (MonDReg),
      .monitor_ready           (monitor_ready),
      .monitor_error           (monitor_error),
      .busy                    (busy)
   );

   always #5 clk = ~clk;

   localparam int K_RD   = 0;
   localparam int K_WR   = 1;
   localparam int K_DONE = 2;

   typedef struct {
      int            kind;
      logic [AW-1:0] addr;
      logic [31:0]   data;
      logic          err;
   } exp_t;

   exp_t        q[$];
   int          checks = 0;
   int          errors = 0;

   // slave controls: 0 random stalls, 1 waitrequest stuck high, 2 no stalls
   int          stall_mode = 0;
   bit          rdv_hold = 1'b0;
   logic [31:0] s_mem [0:255];

   // reference model state
   logic [31:0] m_mem [0:255];
   logic [AW-1:0] m_a = '0;
   logic [31:0] m_d = '0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: actual=%h expected=%h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   task automatic model_cmd(input bit a, input bit b, input bit na, input logic [37:0] j);
      logic [31:0]   d;
      logic [AW-1:0] ad;
      d  = j[34:3];
      ad = j[33:26];
      if (b) begin
         q.push_back('{K_WR, m_a, d, 1'b0});
         m_mem[m_a] = d;
         m_d = d;
         m_a = m_a + 1'b1;
         q.push_back('{K_DONE, '0, m_d, 1'b0});
      end else if (a) begin
         m_a = ad;
         if (j[35]) begin
            q.push_back('{K_RD, m_a, '0, 1'b0});
            m_d = m_mem[m_a];
            m_a = m_a + 1'b1;
            q.push_back('{K_DONE, '0, m_d, 1'b0});
         end
      end else if (na) begin
         q.push_back('{K_RD, m_a, '0, 1'b0});
         m_d = m_mem[m_a];
         m_a = m_a + 1'b1;
         q.push_back('{K_DONE, '0, m_d, 1'b0});
      end
   endtask

   // ---------------- drivers ----------------
   task automatic pulse(input bit a, input bit b, input bit na, input logic [37:0] j);
      @(posedge clk); #1;
      jdo = j;
      take_action_ocimem_a = a;
      take_action_ocimem_b = b;
      take_no_action_ocimem_a = na;
      @(posedge clk); #1;
      take_action_ocimem_a = 1'b0;
      take_action_ocimem_b = 1'b0;
      take_no_action_ocimem_a = 1'b0;
   endtask

   task automatic issue(input bit a, input bit b, input bit na, input logic [37:0] j);
      model_cmd(a, b, na, j);
      pulse(a, b, na, j);
   endtask

   function automatic logic [37:0] mk_jdo(input bit rd, input logic [AW-1:0] ad, input logic [31:0] d, input bit use_d);
      logic [37:0] j;
      j = 38'({$urandom(), $urandom()});
      if (use_d) j[34:3] = d;
      else j[33:26] = ad;
      j[35] = rd;
      return j;
   endfunction

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while (busy && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         checks++;
         errors++;
         $display("FAIL wait_idle: actual busy=1 after %0d cycles expected idle", n);
      end
      @(negedge clk);
   endtask

   // ---------------- memory slave ----------------
   initial begin : slave
      bit            acc_rd, acc_wr, rst_seen, pend;
      logic [AW-1:0] a_s, pend_addr;
      logic [31:0]   d_s;
      int            dly;
      pend = 1'b0;
      dly = 0;
      pend_addr = '0;
      forever begin
         @(negedge clk);
         rst_seen = reset;
         acc_rd   = avm_read && !avm_waitrequest;
         acc_wr   = avm_write && !avm_waitrequest;
         a_s      = avm_address;
         d_s      = avm_writedata;
         @(posedge clk); #1;
         if (rst_seen) begin
            pend = 1'b0;
         end else begin
            if (acc_wr) s_mem[a_s] = d_s;
            if (acc_rd) begin
               pend = 1'b1;
               pend_addr = a_s;
               dly = (stall_mode == 0) ? int'($urandom_range(0, 2)) : 0;
            end
         end
         avm_readdatavalid = 1'b0;
         avm_readdata = $urandom();
         if (pend) begin
            if (!rdv_hold) begin
               if (dly == 0) begin
                  avm_readdatavalid = 1'b1;
                  avm_readdata = s_mem[pend_addr];
                  pend = 1'b0;
               end else begin
                  dly--;
               end
            end
         end else if ($urandom_range(0, 7) == 0) begin
            avm_readdatavalid = 1'b1;   // stray qualifier, must be ignored
         end
         if (stall_mode == 1)      avm_waitrequest = 1'b1;
         else if (stall_mode == 2) avm_waitrequest = 1'b0;
         else                      avm_waitrequest = ($urandom_range(0, 2) == 0);
      end
   end

   // ---------------- monitor / scoreboard ----------------
   task automatic expect_event(input int kind);
      exp_t e;
      if (q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_event: actual kind=%0d expected none", kind);
         return;
      end
      e = q.pop_front();
      check("event_kind", 32'(kind), 32'(e.kind));
      if (e.kind == kind) begin
         if (kind == K_RD) begin
            check("rd_addr", 32'(avm_address), 32'(e.addr));
         end else if (kind == K_WR) begin
            check("wr_addr", 32'(avm_address), 32'(e.addr));
            check("wr_data", avm_writedata, e.data);
         end else begin
            check("mondreg", MonDReg, e.data);
            check("mon_error", 32'(monitor_error), 32'(e.err));
            check("done_idle", {29'd0, busy, avm_read, avm_write}, 32'd0);
         end
      end
   endtask

   initial begin : monitor
      logic prev_ready;
      prev_ready = 1'b1;
      forever begin
         @(negedge clk);
         if (reset !== 1'b1) begin
            if (avm_read && avm_write) begin
               checks++;
               errors++;
               $display("FAIL rd_wr_overlap: actual read=1 write=1 expected exclusive");
            end
            if (avm_read && !avm_waitrequest)  expect_event(K_RD);
            if (avm_write && !avm_waitrequest) expect_event(K_WR);
            if (monitor_ready === 1'b1 && prev_ready === 1'b0) expect_event(K_DONE);
         end
         prev_ready = monitor_ready;
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: actual time limit reached expected finish");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
      $fatal(1, "timeout");
   end

   // ---------------- stimulus ----------------
   initial begin : stim
      logic [37:0] j;
      int          n, cnt, rd_cnt;
      bit          a, b, na;
      for (int i = 0; i < 256; i++) begin
         s_mem[i] = $urandom();
         m_mem[i] = s_mem[i];
      end

      // reset with a coincident command pulse that must be ignored
      repeat (3) @(posedge clk);
      #1;
      jdo = mk_jdo(1'b0, '0, 32'hCAFEF00D, 1'b1);
      take_action_ocimem_b = 1'b1;
      @(posedge clk); #1;
      take_action_ocimem_b = 1'b0;
      reset = 1'b0;
      @(negedge clk);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_read_write", {30'd0, avm_read, avm_write}, 32'd0);
      check("rst_ready", 32'(monitor_ready), 32'd1);
      check("rst_error", 32'(monitor_error), 32'd0);
      check("rst_mondreg", MonDReg, 32'd0);
      check("rst_addr_wdata", 32'(avm_address) | avm_writedata, 32'd0);

      // address load + read at 0x10, no stalls
      stall_mode = 2;
      issue(1'b1, 1'b0, 1'b0, mk_jdo(1'b1, 8'h10, '0, 1'b0));
      cnt = 0;
      rd_cnt = 0;
      while (cnt < 20) begin
         @(negedge clk);
         cnt++;
         if (avm_read) rd_cnt++;
         if (monitor_ready) break;
      end
      check("rd_latency", 32'(cnt), 32'd3);
      check("rd_req_cycles", 32'(rd_cnt), 32'd1);
      wait_idle();
      issue(1'b0, 1'b0, 1'b1, '0);   // next read must be at 0x11
      wait_idle();

      // address-only load of 0xFF, then write with 4 stall cycles
      issue(1'b1, 1'b0, 1'b0, mk_jdo(1'b0, 8'hFF, '0, 1'b0));
      @(negedge clk);
      check("addr_only_ready", 32'(monitor_ready), 32'd1);
      check("addr_only_busy", 32'(busy), 32'd0);
      stall_mode = 1;
      issue(1'b0, 1'b1, 1'b0, mk_jdo(1'b0, '0, 32'h12345678, 1'b1));
      cnt = 0;
      n = 0;
      while (n < 50) begin
         @(negedge clk);
         n++;
         if (avm_write) begin
            cnt++;
            if (cnt == 4) stall_mode = 2;
         end else if (cnt > 0) begin
            break;
         end
      end
      check("wr_hold_cycles", 32'(cnt), 32'd5);
      wait_idle();
      issue(1'b0, 1'b0, 1'b1, '0);   // wrapped address 0x00
      wait_idle();

      // write and no_action together: write only
      issue(1'b0, 1'b1, 1'b1, mk_jdo(1'b1, '0, $urandom(), 1'b1));
      wait_idle();

      // read timeout with waitrequest stuck high
      stall_mode = 1;
      pulse(1'b0, 1'b0, 1'b1, '0);
      q.push_back('{K_DONE, '0, m_d, 1'b1});
      cnt = 0;
      n = 0;
      while (n < 400) begin
         @(negedge clk);
         n++;
         if (avm_read) cnt++;
         else break;
      end
      check("timeout_cycles", 32'(cnt), 32'd255);
      stall_mode = 0;
      wait_idle();
      check("timeout_error_sticky", 32'(monitor_error), 32'd1);
      issue(1'b0, 1'b0, 1'b1, '0);   // clears error, same address as aborted read
      wait_idle();

      // command during a stalled write: ignored, error set, write completes
      stall_mode = 1;
      j = mk_jdo(1'b0, '0, $urandom(), 1'b1);
      pulse(1'b0, 1'b1, 1'b0, j);
      q.push_back('{K_WR, m_a, j[34:3], 1'b0});
      m_mem[m_a] = j[34:3];
      m_d = j[34:3];
      m_a = m_a + 1'b1;
      q.push_back('{K_DONE, '0, m_d, 1'b1});
      @(negedge clk);
      pulse(1'b0, 1'b0, 1'b1, '0);
      @(negedge clk);
      stall_mode = 0;
      wait_idle();

      // reset while waiting for read data
      rdv_hold = 1'b1;
      pulse(1'b0, 1'b0, 1'b1, '0);
      q.push_back('{K_RD, m_a, '0, 1'b0});
      n = 0;
      while (n < 100) begin
         @(negedge clk);
         n++;
         if (avm_read && !avm_waitrequest) break;
      end
      @(posedge clk); #1;
      reset = 1'b1;
      @(negedge clk);
      check("pre_reset_busy", 32'(busy), 32'd1);
      @(negedge clk);
      check("mid_rst_busy", 32'(busy), 32'd0);
      check("mid_rst_read_write", {30'd0, avm_read, avm_write}, 32'd0);
      check("mid_rst_ready", 32'(monitor_ready), 32'd1);
      check("mid_rst_error", 32'(monitor_error), 32'd0);
      check("mid_rst_mondreg", MonDReg, 32'd0);
      check("mid_rst_addr_wdata", 32'(avm_address) | avm_writedata, 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      rdv_hold = 1'b0;
      m_a = '0;
      m_d = '0;
      issue(1'b0, 1'b0, 1'b1, '0);   // read at reset address 0
      wait_idle();

      // randomized command mix
      for (int k = 0; k < 200; k++) begin
         a = 1'b0; b = 1'b0; na = 1'b0;
         case ($urandom_range(0, 6))
            0: b = 1'b1;
            1: a = 1'b1;
            2: a = 1'b1;
            3: na = 1'b1;
            4: begin b = 1'b1; na = 1'b1; end
            5: begin a = 1'b1; na = 1'b1; end
            default: begin a = 1'b1; b = 1'b1; end
         endcase
         j = mk_jdo(1'($urandom_range(0, 1)), 8'($urandom()), $urandom(), 1'($urandom_range(0, 1)));
         issue(a, b, na, j);
         wait_idle();
      end

      repeat (5) @(negedge clk);
      check("queue_drained", 32'(q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/debug_ocimem_ctrl.md
DEBUG_OCIMEM_CTRL -- requirements
Module: debug_ocimem_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8: word-address width of the debug memory port.
REQ-002 Parameter TIMEOUT, default 255: max cycles per bus transaction before abort.
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 jdo  in  38  JTAG data word from the debug-slave sysclk stage.
REQ-006 take_action_ocimem_a  in  1  one-cycle pulse: address load, optional read.
REQ-007 take_action_ocimem_b  in  1  one-cycle pulse: write data word.
REQ-008 take_no_action_ocimem_a  in  1  one-cycle pulse: read at current address.
REQ-009 avm_address  out  ADDR_W  word address to debug memory.
REQ-010 avm_read  out  1  read request, held until accepted.
REQ-011 avm_write  out  1  write request, held until accepted.
REQ-012 avm_writedata  out  32  write data.
REQ-013 avm_waitrequest  in  1  slave stall; request accepted in a cycle where it is 0.
REQ-014 avm_readdata  in  32  read data, valid with avm_readdatavalid.
REQ-015 avm_readdatavalid  in  1  read-data qualifier.
REQ-016 MonDReg  out  32  data register returned to the debug-slave TCK stage.
REQ-017 monitor_ready  out  1  high = no operation in flight, MonDReg valid.
REQ-018 monitor_error  out  1  sticky error flag.
REQ-019 busy  out  1  high while state is not IDLE (combinational from state).

Function
REQ-020 FSM states IDLE, RD_CMD, RD_DATA, WR_CMD; command pulses SHALL be sampled only in IDLE.
REQ-021 Simultaneous pulses in IDLE: priority ocimem_b > ocimem_a > no_action_a; lower-priority pulses dropped silently.
REQ-022 ocimem_a: MonAReg <= jdo[ADDR_W+25:26]; if jdo[35]=1 go RD_CMD, else remain IDLE.
REQ-023 ocimem_b: MonDReg <= jdo[34:3]; go WR_CMD.
REQ-024 no_action_a: go RD_CMD at current MonAReg.
REQ-025 Accepting any command SHALL clear monitor_error and drive monitor_ready=0 from the next cycle (address-only load leaves monitor_ready=1).
REQ-026 RD_CMD: avm_read=1, avm_address=MonAReg; on avm_waitrequest=0 go RD_DATA.
REQ-027 RD_DATA: outputs idle; on avm_readdatavalid=1: MonDReg <= avm_readdata, MonAReg+1, monitor_ready=1, go IDLE.
REQ-028 WR_CMD: avm_write=1, avm_address=MonAReg, avm_writedata=MonDReg; on avm_waitrequest=0: MonAReg+1, monitor_ready=1, go IDLE.
REQ-029 MonAReg increment SHALL wrap 2^ADDR_W-1 -> 0.
REQ-030 Request signals SHALL be registered, asserted the cycle after command sampling; min read latency command-to-MonDReg = 3 cycles.
REQ-031 Timeout counter SHALL reset on entering RD_CMD/WR_CMD and count every non-IDLE cycle; on reaching TIMEOUT: drop avm_read/avm_write, go IDLE, monitor_error=1, monitor_ready=1, MonAReg and MonDReg unchanged.
REQ-032 Any command pulse while busy SHALL be ignored (no state/register change) and set monitor_error=1; in-flight operation completes normally.
REQ-033 avm_readdatavalid outside RD_DATA SHALL be ignored.

Reset
REQ-034 reset SHALL force IDLE immediately, aborting any transfer: MonAReg=0, MonDReg=0, avm_read=avm_write=0, avm_address=0, avm_writedata=0, monitor_ready=1, monitor_error=0, busy=0.
REQ-035 Command pulses coincident with reset SHALL be ignored.

Verification
REQ-036 ocimem_a jdo[33:26]=0x10, jdo[35]=1; waitrequest=0; readdatavalid next cycle with 0xDEADBEEF -> avm_read 1 cycle at addr 0x10, MonDReg=0xDEADBEEF, monitor_ready=1 by cycle 3, MonAReg=0x11.
REQ-037 ocimem_b jdo[34:3]=0x12345678 at MonAReg=0xFF, waitrequest high 4 cycles -> avm_write held 5 cycles, data 0x12345678, MonAReg wraps to 0x00.
REQ-038 ocimem_b and no_action_a same cycle -> write only; no read issued.
REQ-039 Read with waitrequest stuck high -> abort after 255 cycles, monitor_error=1, monitor_ready=1, MonDReg unchanged; next command clears monitor_error.
REQ-040 no_action_a during WR_CMD -> ignored, monitor_error=1, write completes; reset asserted mid-RD_DATA -> all REQ-034 values next cycle.
